hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Central interlock/forwarding scheduler for the 5-stage MIPS pipeline (IF/DE/EXE/MEM/WB).
//  Tracks in-flight destination registers in an internal EXE/MEM/WB scoreboard.
//  Produces per-operand forward selects and a single stall for the decode stage, covering:
//   - load-use hazards
//   - the post-branch resolve window
//   - the multi-cycle MULT/DIV unit
//  Replaces the ad-hoc stall/forward logic spread across decode and execute.
// PARAMETERS
//  BR_STALL_CYCLES  3  cycles decode is held after a branch/jump issues (1..7)
//  MD_LATENCY       4  cycles MULT/DIV occupies HI/LO after issue (1..15)
// PORTS
//  clk           in   1  clock
//  resetn        in   1  synchronous, active-low reset
//  de_valid      in   1  decode holds a valid instruction
//  de_rs         in   5  rs field of decode instruction
//  de_rs_used    in   1  instruction reads rs
//  de_rt         in   5  rt field of decode instruction
//  de_rt_used    in   1  instruction reads rt (R-type source or SW data)
//  de_dst        in   5  destination register (rd / rt / 31 for JAL)
//  de_wen        in   1  instruction writes regfile
//  de_is_load    in   1  instruction is LW
//  de_is_branch  in   1  BEQ/BNE/J/JAL/JR
//  de_is_md      in   1  MULT/MULTU/DIV/DIVU
//  de_uses_hilo  in   1  MFHI/MFLO/MTHI/MTLO
//  fwd_rs_sel    out  2  00 regfile, 01 EXE result, 10 MEM result, 11 WB result
//  fwd_rt_sel    out  2  same encoding for rt
//  stall         out  1  hold PC and decode register; inject bubble into EXE
//  md_busy       out  1  MULT/DIV in progress
// BEHAVIOUR
//  Issue
//   - issue = de_valid & ~stall.
//   - Pipeline has no memory backpressure: EXE->MEM->WB slots shift every cycle.
//  Scoreboard
//   - Each slot holds {v, dst, load}.
//   - On clk: EXE <= issue ? {de_wen, de_dst, de_is_load} : bubble(v=0); MEM <= EXE; WB <= MEM.
//   - A slot with dst==0 never matches.
//  Forwarding (combinational)
//   - Per operand, gated by *_used; priority EXE > MEM > WB > regfile.
//   - EXE match with EXE.load=1 selects 00 and raises load_use instead.
//  Stall
//   - stall = de_valid & (load_use | br_hold | md_hold).
//   - Combinational from inputs and state; no stall when de_valid=0.
//   - load_use (EXE load matching a used operand) lasts exactly 1 cycle.
//   - Next cycle the load sits in MEM, and the same operand forwards 10.
//  Branch FSM
//   - States: BR_IDLE, BR_HOLD.
//   - BR_IDLE -> BR_HOLD on issue & de_is_branch; loads br_cnt = BR_STALL_CYCLES-1.
//   - In BR_HOLD: br_hold=1; br_cnt decrements each cycle.
//   - Exit to BR_IDLE when br_cnt==0; br_hold drops the same cycle.
//   - Net effect: stall high for exactly BR_STALL_CYCLES cycles after the branch issues.
//   - A branch cannot issue during BR_HOLD.
//  MULT/DIV counter (md_cnt, 4 bits)
//   - On issue & de_is_md: md_cnt <= MD_LATENCY.
//   - Otherwise decrements toward 0; md_busy = (md_cnt != 0).
//   - md_hold = md_busy & (de_is_md | de_uses_hilo).
//   - Other instructions issue freely under md_busy.
//  Simultaneous events
//   - Stall causes are ORed.
//   - Branch or MD counters start only on actual issue, never while stalled.
//   - BR and MD counters run independently.
//  Reset
//   - Scoreboard v=0, BR_IDLE, br_cnt=0, md_cnt=0.
//   - Outputs: stall=0, md_busy=0, fwd_*_sel=00.
//   - Reset mid-hold abandons the hold in the next cycle.
// TESTING
//  1. Back-to-back forwarding:
//     - ADDU $3 issues, then ADDU $4,$3,$3 -> fwd_rs_sel=fwd_rt_sel=01, stall=0.
//     - One cycle later a $3 reader -> 10; two cycles later -> 11; three cycles later -> 00.
//  2. Load-use: LW $5 then ADDU $6,$5,$0 -> stall=1 for 1 cycle, then fwd_rs_sel=10, stall=0.
//  3. $0 never forwards: ADDU writes dst=0, then a reader of $0 -> fwd=00, stall=0.
//  4. Branch hold: BEQ issues -> stall=1 for exactly 3 cycles, then 0.
//     - A second BEQ waiting in decode issues on the 4th cycle.
//  5. MULT issues; MFLO in decode -> stall=1 until md_busy drops 4 cycles later.
//     - ADDU in decode during md_busy -> no stall.
//  6. resetn=0 during BR_HOLD with md_busy=1:
//     - Next cycle stall=0, md_busy=0, all fwd selects 00.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline interlock and forwarding scheduler (scoreboard, branch
//            hold FSM, MULT/DIV occupancy counter).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int BR_STALL_CYCLES = 3,
    parameter int MD_LATENCY      = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       de_valid,
    input  logic [4:0] de_rs,
    input  logic       de_rs_used,
    input  logic [4:0] de_rt,
    input  logic       de_rt_used,
    input  logic [4:0] de_dst,
    input  logic       de_wen,
    input  logic       de_is_load,
    input  logic       de_is_branch,
    input  logic       de_is_md,
    input  logic       de_uses_hilo,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic       stall,
    output logic       md_busy
);

    localparam logic [2:0] c_br_init = 3'(BR_STALL_CYCLES - 1);
    localparam logic [3:0] c_md_lat  = 4'(MD_LATENCY);

    typedef enum logic [0:0] {
        BR_IDLE = 1'b0,
        BR_HOLD = 1'b1
    } br_state_t;

    br_state_t  r_br_state;
    logic [2:0] r_br_cnt;
    logic [3:0] r_md_cnt;

    logic       r_exe_v, r_exe_load, r_mem_v, r_wb_v;
    logic [4:0] r_exe_dst, r_mem_dst, r_wb_dst;

    logic [2:0] w_rs_lk, w_rt_lk;
    logic       w_load_use, w_br_hold, w_md_hold, w_issue;

    // Returns {load_hit, sel}; a load in EXE cannot be forwarded yet.
    function automatic logic [2:0] fwd_lookup(
        input logic       used,
        input logic [4:0] src,
        input logic       ev,
        input logic [4:0] ed,
        input logic       el,
        input logic       mv,
        input logic [4:0] md,
        input logic       wv,
        input logic [4:0] wd
    );
        fwd_lookup = 3'b000;
        if (used && src != 5'd0) begin
            if (ev && ed == src)
                fwd_lookup = el ? 3'b100 : 3'b001;
            else if (mv && md == src)
                fwd_lookup = 3'b010;
            else if (wv && wd == src)
                fwd_lookup = 3'b011;
        end
    endfunction

    always_comb begin
        w_rs_lk = fwd_lookup(de_rs_used, de_rs, r_exe_v, r_exe_dst, r_exe_load,
                             r_mem_v, r_mem_dst, r_wb_v, r_wb_dst);
        w_rt_lk = fwd_lookup(de_rt_used, de_rt, r_exe_v, r_exe_dst, r_exe_load,
                             r_mem_v, r_mem_dst, r_wb_v, r_wb_dst);
    end

    assign fwd_rs_sel = w_rs_lk[1:0];
    assign fwd_rt_sel = w_rt_lk[1:0];
    assign w_load_use = w_rs_lk[2] | w_rt_lk[2];
    assign w_br_hold  = (r_br_state == BR_HOLD);
    assign md_busy    = (r_md_cnt != 4'd0);
    assign w_md_hold  = md_busy & (de_is_md | de_uses_hilo);
    assign stall      = de_valid & (w_load_use | w_br_hold | w_md_hold);
    assign w_issue    = de_valid & ~stall;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_exe_v    <= 1'b0;
            r_exe_dst  <= 5'd0;
            r_exe_load <= 1'b0;
            r_mem_v    <= 1'b0;
            r_mem_dst  <= 5'd0;
            r_wb_v     <= 1'b0;
            r_wb_dst   <= 5'd0;
            r_br_state <= BR_IDLE;
            r_br_cnt   <= 3'd0;
            r_md_cnt   <= 4'd0;
        end else begin
            // A stalled decode becomes a bubble in EXE
            r_exe_v    <= w_issue & de_wen;
            r_exe_dst  <= de_dst;
            r_exe_load <= w_issue & de_is_load;
            r_mem_v    <= r_exe_v;
            r_mem_dst  <= r_exe_dst;
            r_wb_v     <= r_mem_v;
            r_wb_dst   <= r_mem_dst;

            case (r_br_state)
                BR_IDLE: begin
                    if (w_issue && de_is_branch) begin
                        r_br_state <= BR_HOLD;
                        r_br_cnt   <= c_br_init;
                    end
                end
                BR_HOLD: begin
                    if (r_br_cnt == 3'd0)
                        r_br_state <= BR_IDLE;
                    else
                        r_br_cnt <= r_br_cnt - 3'd1;
                end
                default: r_br_state <= BR_IDLE;
            endcase

            if (w_issue && de_is_md)
                r_md_cnt <= c_md_lat;
            else if (r_md_cnt != 4'd0)
                r_md_cnt <= r_md_cnt - 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed bench for hazard_ctrl with an age-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int c_br = 3;
    localparam int c_md = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       de_valid, de_rs_used, de_rt_used, de_wen;
    logic       de_is_load, de_is_branch, de_is_md, de_uses_hilo;
    logic [4:0] de_rs, de_rt, de_dst;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
    logic       stall, md_busy;

    int n_vec = 0;
    int n_err = 0;

    hazard_ctrl #(.BR_STALL_CYCLES(c_br), .MD_LATENCY(c_md)) u_dut (
        .clk(clk), .resetn(resetn), .de_valid(de_valid),
        .de_rs(de_rs), .de_rs_used(de_rs_used), .de_rt(de_rt), .de_rt_used(de_rt_used),
        .de_dst(de_dst), .de_wen(de_wen), .de_is_load(de_is_load),
        .de_is_branch(de_is_branch), .de_is_md(de_is_md), .de_uses_hilo(de_uses_hilo),
        .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .stall(stall), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: history indexed by age since issue (1=EXE, 2=MEM, 3=WB)
    logic       m_ok = 1'b0;
    logic       e_issue = 1'b0;
    logic       hv[1:3];
    logic [4:0] hd[1:3];
    logic       hl[1:3];
    int         br_age, md_age;

    function automatic logic [2:0] m_fwd(input logic used, input logic [4:0] src);
        logic found;
        m_fwd = 3'b000;
        found = 1'b0;
        if (used && src != 5'd0) begin
            for (int k = 1; k <= 3; k++) begin
                if (!found && hv[k] && hd[k] == src) begin
                    found = 1'b1;
                    m_fwd = (k == 1 && hl[1]) ? 3'b100 : 3'(k);
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        logic [2:0] rs_e, rt_e;
        logic       br_h, md_b, st;
        if (m_ok) begin
            rs_e = m_fwd(de_rs_used, de_rs);
            rt_e = m_fwd(de_rt_used, de_rt);
            br_h = (br_age >= 1 && br_age <= c_br);
            md_b = (md_age >= 1 && md_age <= c_md);
            st   = de_valid & (rs_e[2] | rt_e[2] | br_h | (md_b & (de_is_md | de_uses_hilo)));
            chk("model_stall", {3'b0, stall}, {3'b0, st});
            chk("model_md_busy", {3'b0, md_busy}, {3'b0, md_b});
            chk("model_fwd_rs", {2'b0, fwd_rs_sel}, {2'b0, rs_e[1:0]});
            chk("model_fwd_rt", {2'b0, fwd_rt_sel}, {2'b0, rt_e[1:0]});
            e_issue <= de_valid & ~st;
        end
    end

    always @(posedge clk) begin
        if (!resetn) begin
            m_ok   <= 1'b1;
            br_age <= 1000;
            md_age <= 1000;
            for (int k = 1; k <= 3; k++) begin
                hv[k] <= 1'b0;
                hd[k] <= 5'd0;
                hl[k] <= 1'b0;
            end
        end else if (m_ok) begin
            hv[3] <= hv[2]; hd[3] <= hd[2]; hl[3] <= hl[2];
            hv[2] <= hv[1]; hd[2] <= hd[1]; hl[2] <= hl[1];
            hv[1] <= e_issue & de_wen;
            hd[1] <= de_dst;
            hl[1] <= e_issue & de_is_load;
            br_age <= (e_issue && de_is_branch) ? 1 : ((br_age < 1000) ? br_age + 1 : br_age);
            md_age <= (e_issue && de_is_md) ? 1 : ((md_age < 1000) ? md_age + 1 : md_age);
        end
    end

    task automatic drv(input logic v, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic [4:0] dst,
                       input logic wen, input logic ld, input logic br,
                       input logic md, input logic hl_i);
        de_valid = v; de_rs = rs; de_rs_used = rsu; de_rt = rt; de_rt_used = rtu;
        de_dst = dst; de_wen = wen; de_is_load = ld; de_is_branch = br;
        de_is_md = md; de_uses_hilo = hl_i;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        idle();
        cyc(); cyc();
        resetn = 1'b1;
        neg();
        chk("reset_stall", {3'b0, stall}, 4'd0);
        chk("reset_md_busy", {3'b0, md_busy}, 4'd0);
        chk("reset_fwd_rs", {2'b0, fwd_rs_sel}, 4'd0);
        cyc();

        // Back-to-back forwarding through EXE, MEM, WB, then regfile
        drv(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 0);
        neg(); chk("addu3_stall", {3'b0, stall}, 4'd0);
        cyc();
        drv(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 0, 0, 0);
        neg(); chk("fwd_exe_rs", {2'b0, fwd_rs_sel}, 4'd1);
        chk("fwd_exe_rt", {2'b0, fwd_rt_sel}, 4'd1);
        chk("fwd_exe_stall", {3'b0, stall}, 4'd0);
        cyc();
        drv(1, 5'd3, 1, 5'd0, 0, 5'd7, 1, 0, 0, 0, 0);
        neg(); chk("fwd_mem_rs", {2'b0, fwd_rs_sel}, 4'd2);
        cyc();
        neg(); chk("fwd_wb_rs", {2'b0, fwd_rs_sel}, 4'd3);
        cyc();
        drv(1, 5'd3, 1, 5'd0, 0, 5'd10, 1, 0, 0, 0, 0);
        neg(); chk("fwd_rf_rs", {2'b0, fwd_rs_sel}, 4'd0);
        cyc();

        // Load-use: one bubble, then MEM forward
        drv(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0);
        cyc();
        drv(1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0, 0, 0, 0);
        neg(); chk("lu_stall", {3'b0, stall}, 4'd1);
        chk("lu_fwd_rs", {2'b0, fwd_rs_sel}, 4'd0);
        cyc();
        neg(); chk("lu_after_stall", {3'b0, stall}, 4'd0);
        chk("lu_after_fwd", {2'b0, fwd_rs_sel}, 4'd2);
        cyc();

        // $0 never forwards
        drv(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0, 0, 0);
        cyc();
        drv(1, 5'd0, 1, 5'd0, 1, 5'd11, 1, 0, 0, 0, 0);
        neg(); chk("r0_fwd_rs", {2'b0, fwd_rs_sel}, 4'd0);
        chk("r0_fwd_rt", {2'b0, fwd_rt_sel}, 4'd0);
        chk("r0_stall", {3'b0, stall}, 4'd0);
        cyc();

        // Branch hold, second branch waits then issues
        drv(1, 5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 1, 0, 0);
        neg(); chk("br1_issue", {3'b0, stall}, 4'd0);
        cyc();
        for (int i = 0; i < c_br; i++) begin
            neg(); chk("br_hold", {3'b0, stall}, 4'd1);
            cyc();
        end
        neg(); chk("br2_issue", {3'b0, stall}, 4'd0);
        cyc();
        idle();
        neg(); chk("br_novalid", {3'b0, stall}, 4'd0);
        cyc(); cyc(); cyc();

        // MULT occupancy against an MFLO, then an ADDU under md_busy
        drv(1, 5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 0, 1, 0);
        neg(); chk("mult_issue", {3'b0, stall}, 4'd0);
        cyc();
        drv(1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 0, 0, 0, 1);
        for (int i = 0; i < c_md; i++) begin
            neg(); chk("mflo_stall", {3'b0, stall}, 4'd1);
            chk("mflo_busy", {3'b0, md_busy}, 4'd1);
            cyc();
        end
        neg(); chk("mflo_go", {3'b0, stall}, 4'd0);
        chk("md_done", {3'b0, md_busy}, 4'd0);
        cyc();
        drv(1, 5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 0, 1, 0);
        cyc();
        drv(1, 5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 0, 0, 0);
        neg(); chk("addu_md_stall", {3'b0, stall}, 4'd0);
        chk("addu_md_busy", {3'b0, md_busy}, 4'd1);
        cyc();
        idle();
        cyc(); cyc(); cyc(); cyc();

        // Reset during branch hold with MULT busy
        drv(1, 5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 0, 1, 0);
        cyc();
        drv(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 0, 0, 0);
        cyc();
        drv(1, 5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 1, 0, 0);
        cyc();
        drv(1, 5'd9, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1);
        resetn = 1'b0;
        neg(); chk("prerst_stall", {3'b0, stall}, 4'd1);
        chk("prerst_fwd_rs", {2'b0, fwd_rs_sel}, 4'd2);
        cyc();
        resetn = 1'b1;
        neg(); chk("rst_stall", {3'b0, stall}, 4'd0);
        chk("rst_md_busy", {3'b0, md_busy}, 4'd0);
        chk("rst_fwd_rs", {2'b0, fwd_rs_sel}, 4'd0);
        chk("rst_fwd_rt", {2'b0, fwd_rt_sel}, 4'd0);
        cyc();
        idle();
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
